// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the forwarding/hazard unit: in-flight
// writeback entry layout and register-address constants.
package pipe_hazard_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] X0_IDX = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Per-operand priority match: picks the youngest in-flight writer of i_rs,
// selects its stage data (or the RF value) and flags a not-yet-ready load.
module hazard_match
    import pipe_hazard_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FWD_DEPTH = 2,
    parameter int LD_LAT    = 1
) (
    input  entry_t [FWD_DEPTH-1:0]           i_entries,
    input  logic   [REG_AW-1:0]              i_rs,
    input  logic   [XLEN-1:0]                i_rf,
    input  logic   [FWD_DEPTH-1:0][XLEN-1:0] i_stage_data,
    output logic   [XLEN-1:0]                o_fwd,
    output logic   [FWD_DEPTH:0]             o_sel,
    output logic                             o_not_ready
);

    logic [FWD_DEPTH-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < FWD_DEPTH; gi++) begin : g_match
            assign w_match[gi] = i_entries[gi].valid && i_entries[gi].we &&
                                 (i_entries[gi].rd == i_rs) && (i_rs != X0_IDX);
        end
    endgenerate

    // Walk oldest to youngest so the youngest matching stage overrides.
    always_comb begin
        o_sel       = '0;
        o_sel[0]    = 1'b1;
        o_fwd       = i_rf;
        o_not_ready = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_sel        = '0;
                o_sel[k + 1] = 1'b1;
                o_fwd        = i_stage_data[k];
                o_not_ready  = i_entries[k].ld && (k < LD_LAT);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Operand forwarding and load-use hazard unit. Defining HAZARD_PERF_EN adds
// the stall_cnt / fwd_cnt performance counter outputs.
module pipe_hazard_unit
    import pipe_hazard_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FWD_DEPTH = 2,
    parameter int LD_LAT    = 1
) (
    input  logic                           clk,
    input  logic                           rstB,
    input  logic                           clkEn,
    input  logic                           issue_valid,
    input  logic [REG_AW-1:0]              issue_rd,
    input  logic                           issue_we,
    input  logic                           issue_ld,
    input  logic [REG_AW-1:0]              rs1,
    input  logic [REG_AW-1:0]              rs2,
    input  logic [XLEN-1:0]                rs1_rf,
    input  logic [XLEN-1:0]                rs2_rf,
    input  logic [FWD_DEPTH-1:0][XLEN-1:0] stage_data,
    input  logic                           flush,
    output logic [XLEN-1:0]                rs1_fwd,
    output logic [XLEN-1:0]                rs2_fwd,
    output logic [FWD_DEPTH:0]             fwd_sel1,
    output logic [FWD_DEPTH:0]             fwd_sel2,
    output logic                           stall
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]                    stall_cnt,
    output logic [31:0]                    fwd_cnt
`endif
);

    generate
        if (FWD_DEPTH < 1 || FWD_DEPTH > 4 || LD_LAT < 0 || LD_LAT > FWD_DEPTH - 1) begin : g_bad_param
            $error("pipe_hazard_unit: illegal FWD_DEPTH/LD_LAT combination");
        end
    endgenerate

    entry_t [FWD_DEPTH-1:0] r_entries;
    entry_t                 w_issue_entry;
    logic                   w_nr1;
    logic                   w_nr2;
    logic                   w_accept;

    assign w_issue_entry = '{valid: 1'b1, rd: issue_rd, we: issue_we, ld: issue_ld};
    assign stall         = issue_valid && clkEn && !flush && (w_nr1 || w_nr2);
    assign w_accept      = issue_valid && !stall && !flush;

    // Flush kills both the issuing instruction and the current stage-0 entry.
    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_entries <= '0;
        end else if (clkEn) begin
            r_entries[0] <= w_accept ? w_issue_entry : '0;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                if (k == 1 && flush) begin
                    r_entries[k] <= '0;
                end else begin
                    r_entries[k] <= r_entries[k-1];
                end
            end
        end
    end

    hazard_match #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH), .LD_LAT(LD_LAT)) u_match_rs1 (
        .i_entries    (r_entries),
        .i_rs         (rs1),
        .i_rf         (rs1_rf),
        .i_stage_data (stage_data),
        .o_fwd        (rs1_fwd),
        .o_sel        (fwd_sel1),
        .o_not_ready  (w_nr1)
    );

    hazard_match #(.XLEN(XLEN), .FWD_DEPTH(FWD_DEPTH), .LD_LAT(LD_LAT)) u_match_rs2 (
        .i_entries    (r_entries),
        .i_rs         (rs2),
        .i_rf         (rs2_rf),
        .i_stage_data (stage_data),
        .o_fwd        (rs2_fwd),
        .o_sel        (fwd_sel2),
        .o_not_ready  (w_nr2)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_fwd_cnt;

    always_ff @(posedge clk or negedge rstB) begin
        if (!rstB) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (clkEn && w_accept && (!fwd_sel1[0] || !fwd_sel2[0]) && (r_fwd_cnt != '1)) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign fwd_cnt   = r_fwd_cnt;
`endif

endmodule

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter FWD_DEPTH, default 2, legal 1..4, number of in-flight writeback stages tracked; stage 0 is youngest.
REQ-003 SHALL have parameter LD_LAT, default 1, legal 0..FWD_DEPTH-1, first stage index at which load data is forwardable; illegal values SHALL stop elaboration.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rstB, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port clkEn, input, 1, global advance enable.
REQ-007 SHALL have port issue_valid, input, 1, an instruction is issuing this cycle.
REQ-008 SHALL have ports issue_rd (input, 5), issue_we (input, 1) and issue_ld (input, 1), giving the destination register, register write, and load flag of the issuing instruction.
REQ-009 SHALL have ports rs1 and rs2, input, 5 each, source registers of the issuing instruction.
REQ-010 SHALL have ports rs1_rf and rs2_rf, input, XLEN each, register-file read data.
REQ-011 SHALL have port stage_data, input, FWD_DEPTH x XLEN, result data currently held at each tracked stage.
REQ-012 SHALL have port flush, input, 1, kill the issuing instruction and the stage-0 entry.
REQ-013 SHALL have ports rs1_fwd and rs2_fwd, output, XLEN each, resolved operand data.
REQ-014 SHALL have ports fwd_sel1 and fwd_sel2, output, FWD_DEPTH+1 each, one-hot source select: bit 0 is the RF, bit k+1 is stage k.
REQ-015 SHALL have port stall, output, 1, hold issue; the issuing instruction is not accepted this cycle.

Function
REQ-016 SHALL keep a FWD_DEPTH-entry shift register; each entry holds {valid, rd, we, ld}.
REQ-017 On a clk edge with clkEn=1, entry k SHALL move to entry k+1 and the oldest entry SHALL be discarded.
REQ-018 On the same edge, entry 0 SHALL load the issue fields if issue_valid && !stall && !flush, and SHALL become a bubble (valid=0) otherwise.
REQ-019 With clkEn=0, all entries SHALL hold and stall SHALL be 0.
REQ-020 Entry k SHALL match source rsN when valid && we && rd==rsN && rsN!=0; register x0 SHALL always read as RF data.
REQ-021 When several entries match, the lowest index (youngest) SHALL win; rsN_fwd SHALL equal stage_data[k] for the winner, and rsN_rf when nothing matches.
REQ-022 The winning entry SHALL be not-ready iff ld && k<LD_LAT; a not-ready winner SHALL assert stall.
REQ-023 stall SHALL be combinational, and SHALL equal issue_valid && clkEn && !flush && (rs1 not-ready || rs2 not-ready).
REQ-024 A stalled load SHALL age through the shift register; stall SHALL deassert without further input once the load reaches stage LD_LAT, a total of LD_LAT-k bubbles.
REQ-025 rs1 and rs2 SHALL resolve independently; rs1==rs2 SHALL yield identical outputs.
REQ-026 When flush and stall conditions coincide, flush SHALL win: stall=0 and the issue is dropped.
REQ-027 Forwarding latency SHALL be zero cycles (combinational, same cycle as issue).

Reset
REQ-028 On rstB low, all entries SHALL become valid=0 asynchronously, including mid-stall; the next cycle SHALL give stall=0, rsN_fwd=rsN_rf and fwd_selN=1.
REQ-029 Release of rstB SHALL be synchronised externally; no entry SHALL load on the first edge after release unless issue_valid=1.

Configuration
REQ-030 Macro HAZARD_PERF_EN SHALL, when defined, add outputs stall_cnt (32) and fwd_cnt (32).
REQ-031 With HAZARD_PERF_EN defined, stall_cnt SHALL increment on each clkEn edge with stall=1.
REQ-032 With HAZARD_PERF_EN defined, fwd_cnt SHALL increment on each accepted issue with any non-RF select, saturating at all-ones.
REQ-033 With HAZARD_PERF_EN defined, both counters SHALL reset to 0.
REQ-034 With HAZARD_PERF_EN undefined, the ports and counters SHALL be absent.

Structure
REQ-035 Package pipe_hazard_pkg SHALL hold the entry typedef (valid, rd, we, ld), the REG_AW=5 constant and the x0 index constant.
REQ-036 Sub-module hazard_match SHALL perform the per-operand priority match, select and ready logic, instantiated twice (rs1, rs2).

Verification
REQ-037 Issue ADD x5; next cycle issue rs1=x5, stage_data[0]=0x11 -> rs1_fwd=0x11, fwd_sel1=0b010, stall=0.
REQ-038 LD_LAT=1: issue LW x6; next cycle issue rs2=x6 -> stall=1 for one cycle; then rs2_fwd=stage_data[1], fwd_sel2=0b100.
REQ-039 Entry 0 and entry 1 both write x7, with data 0xA and 0xB -> rs1_fwd=0xA (youngest wins).
REQ-040 Issue ADDI x0; next cycle issue rs1=x0, rs1_rf=0 -> fwd_sel1=0b001, rs1_fwd=0.
REQ-041 Load-use stall with flush=1 in the same cycle -> stall=0, entry 0 bubble; next cycle no match.
REQ-042 Assert rstB low mid-stall -> stall=0 immediately after reset, all fwd_sel=RF; with HAZARD_PERF_EN defined, stall_cnt=0.
